// File: rtl/bullet_scheduler.sv
// Shared bullet-slot allocator for the two-tank game: edge-detects shoot requests,
// arbitrates one grant per frame and retires slots on lifetime expiry or hit.
module bullet_scheduler #(
    parameter int unsigned NUM_SLOTS    = 8,
    parameter logic [9:0]  LIFETIME     = 10'd600,
    parameter logic [5:0]  COOLDOWN     = 6'd15,
    parameter int unsigned MAX_PER_TANK = 4
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 Shoot1,
    input  logic                 Shoot2,
    input  logic [9:0]           Tank1X,
    input  logic [9:0]           Tank1Y,
    input  logic [9:0]           Tank2X,
    input  logic [9:0]           Tank2Y,
    input  logic [5:0]           Angle1,
    input  logic [5:0]           Angle2,
    input  logic [NUM_SLOTS-1:0] bullet_hit,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic                 launch_valid,
    output logic [2:0]           launch_slot,
    output logic                 launch_owner,
    output logic [9:0]           launch_x,
    output logic [9:0]           launch_y,
    output logic [5:0]           launch_angle
);

    logic                 r_prev1, r_prev2;
    logic                 r_pend1, r_pend2;
    logic                 r_prio;
    logic [5:0]           r_cool1, r_cool2;
    logic [9:0]           r_life [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_active, r_owner;
    logic                 r_lvalid, r_lowner;
    logic [2:0]           r_lslot;
    logic [9:0]           r_lx, r_ly;
    logic [5:0]           r_langle;

    logic       w_req1, w_req2, w_elig1, w_elig2, w_grant1, w_grant2, w_grant;
    logic       w_any_free;
    logic [2:0] w_free_idx, w_cnt1, w_cnt2;

    // A fresh edge is evaluated in the same frame it is seen, giving one-frame latency.
    always_comb begin
        w_req1     = r_pend1 | (Shoot1 & ~r_prev1 & (r_cool1 == 6'd0));
        w_req2     = r_pend2 | (Shoot2 & ~r_prev2 & (r_cool2 == 6'd0));
        w_cnt1     = 3'd0;
        w_cnt2     = 3'd0;
        w_free_idx = 3'd0;
        w_any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_idx = 3'(i);
                w_any_free = 1'b1;
            end
            w_cnt1 = w_cnt1 + 3'(r_active[i] & ~r_owner[i]);
            w_cnt2 = w_cnt2 + 3'(r_active[i] & r_owner[i]);
        end
        w_elig1  = w_req1 & (w_cnt1 < 3'(MAX_PER_TANK)) & w_any_free;
        w_elig2  = w_req2 & (w_cnt2 < 3'(MAX_PER_TANK)) & w_any_free;
        w_grant1 = w_elig1 & (~w_elig2 | ~r_prio);
        w_grant2 = w_elig2 & (~w_elig1 | r_prio);
        w_grant  = w_grant1 | w_grant2;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_prev1  <= 1'b0;
            r_prev2  <= 1'b0;
            r_pend1  <= 1'b0;
            r_pend2  <= 1'b0;
            r_prio   <= 1'b0;
            r_cool1  <= 6'd0;
            r_cool2  <= 6'd0;
            r_active <= '0;
            r_owner  <= '0;
            r_lvalid <= 1'b0;
            r_lowner <= 1'b0;
            r_lslot  <= 3'd0;
            r_lx     <= 10'd0;
            r_ly     <= 10'd0;
            r_langle <= 6'd0;
            for (int i = 0; i < NUM_SLOTS; i++) r_life[i] <= 10'd0;
        end else begin
            r_prev1  <= Shoot1;
            r_prev2  <= Shoot2;
            // Ineligible requests drop; only the arbitration loser stays pending.
            r_pend1  <= w_elig1 & ~w_grant1;
            r_pend2  <= w_elig2 & ~w_grant2;
            if (w_elig1 && w_elig2) r_prio <= ~r_prio;

            if (w_grant1)              r_cool1 <= COOLDOWN;
            else if (r_cool1 != 6'd0)  r_cool1 <= r_cool1 - 6'd1;
            if (w_grant2)              r_cool2 <= COOLDOWN;
            else if (r_cool2 != 6'd0)  r_cool2 <= r_cool2 - 6'd1;

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_active[i]) begin
                    if (bullet_hit[i] || r_life[i] <= 10'd1) begin
                        r_active[i] <= 1'b0;
                        r_owner[i]  <= 1'b0;
                        r_life[i]   <= 10'd0;
                    end else begin
                        r_life[i]   <= r_life[i] - 10'd1;
                    end
                end else if (w_grant && w_free_idx == 3'(i)) begin
                    r_active[i] <= 1'b1;
                    r_owner[i]  <= w_grant2;
                    r_life[i]   <= LIFETIME;
                end
            end

            r_lvalid <= w_grant;
            if (w_grant) begin
                r_lslot  <= w_free_idx;
                r_lowner <= w_grant2;
                r_lx     <= w_grant2 ? Tank2X : Tank1X;
                r_ly     <= w_grant2 ? Tank2Y : Tank1Y;
                r_langle <= w_grant2 ? Angle2 : Angle1;
            end
        end
    end

    assign slot_active  = r_active;
    assign slot_owner   = r_owner;
    assign launch_valid = r_lvalid;
    assign launch_slot  = r_lslot;
    assign launch_owner = r_lowner;
    assign launch_x     = r_lx;
    assign launch_y     = r_ly;
    assign launch_angle = r_langle;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: vector table for arbitration and retire,
// hand sequences for cooldown, cap, lifetime and asynchronous reset.
module tb_bullet_scheduler;

    logic       frame_clk, Reset, Shoot1, Shoot2;
    logic [9:0] Tank1X, Tank1Y, Tank2X, Tank2Y;
    logic [5:0] Angle1, Angle2;
    logic [7:0] bullet_hit, slot_active, slot_owner;
    logic       launch_valid, launch_owner;
    logic [2:0] launch_slot;
    logic [9:0] launch_x, launch_y;
    logic [5:0] launch_angle;

    int checks = 0;
    int failures = 0;

    bullet_scheduler dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .Shoot1(Shoot1), .Shoot2(Shoot2),
        .Tank1X(Tank1X), .Tank1Y(Tank1Y), .Tank2X(Tank2X), .Tank2Y(Tank2Y),
        .Angle1(Angle1), .Angle2(Angle2), .bullet_hit(bullet_hit),
        .slot_active(slot_active), .slot_owner(slot_owner),
        .launch_valid(launch_valid), .launch_slot(launch_slot),
        .launch_owner(launch_owner), .launch_x(launch_x), .launch_y(launch_y),
        .launch_angle(launch_angle)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         pre_idle;
        logic       s1, s2;
        logic [7:0] hit;
        logic       lv;
        logic [2:0] slot;
        logic       own;
        logic [7:0] act, owners;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Shoot1 = 1'b0; Shoot2 = 1'b0; bullet_hit = 8'h00;
        step();
        Reset = 1'b0;
    endtask

    task automatic chk_launch(input string tag, input logic [2:0] slot, input logic own);
        chk({tag, "_slot"}, 32'(launch_slot), 32'(slot));
        chk({tag, "_owner"}, 32'(launch_owner), 32'(own));
        chk({tag, "_x"}, 32'(launch_x), own ? 32'd100 : 32'd300);
        chk({tag, "_y"}, 32'(launch_y), own ? 32'd50 : 32'd250);
        chk({tag, "_ang"}, 32'(launch_angle), own ? 32'd33 : 32'd8);
    endtask

    initial begin
        int n;
        int launches;
        Tank1X = 10'd300; Tank1Y = 10'd250; Angle1 = 6'd8;
        Tank2X = 10'd100; Tank2Y = 10'd50;  Angle2 = 6'd33;

        // Reset state
        do_reset();
        Reset = 1'b1;
        #1;
        chk("rst_active", 32'(slot_active), 32'h0);
        chk("rst_owner", 32'(slot_owner), 32'h0);
        chk("rst_lv", 32'(launch_valid), 32'h0);
        chk("rst_lx", 32'(launch_x), 32'h0);
        chk("rst_ang", 32'(launch_angle), 32'h0);
        Reset = 1'b0;

        // First press at frame 2, then held 40 frames
        step(); step();
        Shoot1 = 1'b1;
        step();
        chk("first_lv", 32'(launch_valid), 32'h1);
        chk_launch("first", 3'd0, 1'b0);
        chk("first_act", 32'(slot_active), 32'h01);
        launches = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (launch_valid) launches++;
        end
        chk("hold_launches", 32'(launches), 32'd1);
        Shoot1 = 1'b0;

        // Cooldown: re-press at +5 ignored, at +16 launches slot 1
        do_reset();
        Shoot1 = 1'b1;
        step();
        chk("cd_grant_lv", 32'(launch_valid), 32'h1);
        for (int k = 1; k <= 16; k++) begin
            Shoot1 = (k == 5 || k == 16);
            step();
            if (k == 16) begin
                chk("cd16_lv", 32'(launch_valid), 32'h1);
                chk("cd16_slot", 32'(launch_slot), 32'd1);
            end else if (k == 5 || k == 6) begin
                chk($sformatf("cd%0d_lv", k), 32'(launch_valid), 32'h0);
            end
        end
        Shoot1 = 1'b0;

        // Arbitration and retire vectors
        tbl[0] = '{0,  1'b1, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h01, 8'h00};
        tbl[1] = '{0,  1'b1, 1'b1, 8'h00, 1'b1, 3'd1, 1'b1, 8'h03, 8'h02};
        tbl[2] = '{16, 1'b1, 1'b1, 8'h00, 1'b1, 3'd2, 1'b1, 8'h07, 8'h06};
        tbl[3] = '{0,  1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 8'h0F, 8'h06};
        tbl[4] = '{0,  1'b0, 1'b0, 8'h02, 1'b0, 3'd3, 1'b0, 8'h0D, 8'h04};
        tbl[5] = '{0,  1'b0, 1'b0, 8'h02, 1'b0, 3'd3, 1'b0, 8'h0D, 8'h04};
        tbl[6] = '{0,  1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 8'h0D, 8'h04};
        tbl[7] = '{0,  1'b0, 1'b0, 8'h01, 1'b0, 3'd3, 1'b0, 8'h0C, 8'h04};
        tbl[8] = '{0,  1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 8'h0C, 8'h04};
        tbl[9] = '{16, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h0D, 8'h04};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < tbl[i].pre_idle; j++) begin
                Shoot1 = 1'b0; Shoot2 = 1'b0; bullet_hit = 8'h00;
                step();
            end
            Shoot1 = tbl[i].s1; Shoot2 = tbl[i].s2; bullet_hit = tbl[i].hit;
            step();
            chk($sformatf("tbl%0d_lv", i), 32'(launch_valid), 32'(tbl[i].lv));
            chk_launch($sformatf("tbl%0d", i), tbl[i].slot, tbl[i].own);
            chk($sformatf("tbl%0d_act", i), 32'(slot_active), 32'(tbl[i].act));
            chk($sformatf("tbl%0d_own", i), 32'(slot_owner), 32'(tbl[i].owners));
        end
        Shoot1 = 1'b0; Shoot2 = 1'b0; bullet_hit = 8'h00;

        // Live-bullet cap: fifth shot rejected and not queued
        do_reset();
        for (int k = 0; k < 5; k++) begin
            Shoot1 = 1'b1;
            step();
            chk($sformatf("cap%0d_lv", k), 32'(launch_valid), (k < 4) ? 32'h1 : 32'h0);
            Shoot1 = 1'b0;
            for (int j = 0; j < 19; j++) step();
        end
        chk("cap_act", 32'(slot_active), 32'h0F);
        chk("cap_own", 32'(slot_owner), 32'h00);
        bullet_hit = 8'h01;
        step();
        bullet_hit = 8'h00;
        chk("cap_hit_act", 32'(slot_active), 32'h0E);
        launches = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (launch_valid) launches++;
        end
        chk("cap_no_queue", 32'(launches), 32'd0);

        // Lifetime expiry
        do_reset();
        Shoot1 = 1'b1;
        step();
        Shoot1 = 1'b0;
        chk("life_grant_act", 32'(slot_active), 32'h01);
        n = 0;
        while (n < 700 && slot_active[0]) begin
            step();
            n++;
        end
        chk("life_frames", 32'(n), 32'd600);

        // Asynchronous reset right after a grant
        do_reset();
        Shoot1 = 1'b1;
        step();
        chk("ar_lv_before", 32'(launch_valid), 32'h1);
        Reset = 1'b1;
        Shoot1 = 1'b0;
        #1;
        chk("ar_lv", 32'(launch_valid), 32'h0);
        chk("ar_act", 32'(slot_active), 32'h0);
        #1;
        Reset = 1'b0;
        step();
        Shoot1 = 1'b1;
        step();
        chk("ar_post_lv", 32'(launch_valid), 32'h1);
        chk("ar_post_slot", 32'(launch_slot), 32'd0);
        chk("ar_post_act", 32'(slot_active), 32'h01);
        Shoot1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
